// File: rtl/maquina_de_cafe.sv
// Control FSM for a coin-operated coffee/tea vending machine; registered Moore command on out.
// Optional tea path: define TE_EN to enable it (default build serves coffee only).
module maquina_de_cafe #(
  parameter int TIMEOUT      = 16,
  parameter int SERVE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hm,
  input  logic       ha,
  input  logic       bp,
  input  logic       bc,
  input  logic       bt,
  input  logic       hc,
  input  logic       md,
  input  logic       mc,
  output logic [2:0] out,
  output logic [3:0] state
);

  localparam int MAX_CNT = (TIMEOUT > SERVE_CYCLES) ? TIMEOUT : SERVE_CYCLES;
  localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CW-1:0] LAST_WAIT  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] LAST_SERVE = CW'(SERVE_CYCLES - 1);

  localparam logic [2:0] CMD_IDLE   = 3'b000;
  localparam logic [2:0] CMD_COFFEE = 3'b001;
  localparam logic [2:0] CMD_TEA    = 3'b010;
  localparam logic [2:0] CMD_RETURN = 3'b100;

  typedef enum logic [3:0] {
    IDLE        = 4'b0000,
    AGUA        = 4'b0001,
    DEVOLVER    = 4'b0010,
    BOTON       = 4'b0011,
    CAFE        = 4'b0100,
    MONEDA      = 4'b0101,
    SERVIR_CAFE = 4'b0110,
    SERVIR_TE   = 4'b0111
  } state_t;

  state_t          st, st_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic            sel_te, sel_te_next;
  logic [2:0]      out_next;
  logic            wait_done, serve_done;
  logic            tea_req;

`ifdef TE_EN
  assign tea_req = bp & bt;
`else
  // Without the tea path bt has no effect; a tea-only press just waits in BOTON.
  logic unused_bt;
  assign unused_bt = bt;
  assign tea_req   = 1'b0;
`endif

  assign wait_done  = (cnt == LAST_WAIT);
  assign serve_done = (cnt == LAST_SERVE);

  // One counter serves both roles: wait-timeout in AGUA..MONEDA, hold time in SERVIR_*.
  always_comb begin
    st_next     = st;
    sel_te_next = sel_te;
    cnt_next    = cnt + 1'b1;

    case (st)
      IDLE: begin
        sel_te_next = 1'b0;
        cnt_next    = '0;
        if (hm) st_next = AGUA;
      end
      AGUA: begin
        if (ha)             st_next = BOTON;
        else if (wait_done) st_next = DEVOLVER;
      end
      BOTON: begin
        if (bp && bc) begin
          st_next     = CAFE;
          sel_te_next = 1'b0;
        end else if (tea_req) begin
          st_next     = MONEDA;
          sel_te_next = 1'b1;
        end else if (wait_done) begin
          st_next = DEVOLVER;
        end
      end
      CAFE: begin
        if (hc)             st_next = MONEDA;
        else if (wait_done) st_next = DEVOLVER;
      end
      MONEDA: begin
        // An insufficient coin wins even when the full-price flag is also set.
        if (mc)             st_next = DEVOLVER;
        else if (md)        st_next = sel_te ? SERVIR_TE : SERVIR_CAFE;
        else if (wait_done) st_next = DEVOLVER;
      end
      SERVIR_CAFE, SERVIR_TE: begin
        if (serve_done) st_next = IDLE;
      end
      DEVOLVER: st_next = IDLE;
      default:  st_next = IDLE;
    endcase

    if (st_next != st) cnt_next = '0;
  end

  always_comb begin
    out_next = CMD_IDLE;
    case (st_next)
      SERVIR_CAFE: out_next = CMD_COFFEE;
      SERVIR_TE:   out_next = CMD_TEA;
      DEVOLVER:    out_next = CMD_RETURN;
      default:     out_next = CMD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= IDLE;
      cnt    <= '0;
      sel_te <= 1'b0;
      out    <= CMD_IDLE;
    end else begin
      st     <= st_next;
      cnt    <= cnt_next;
      sel_te <= sel_te_next;
      out    <= out_next;
    end
  end

  assign state = st;

endmodule

// File: tb/tb_maquina_de_cafe.sv
// Bench for maquina_de_cafe: directed scenarios plus randomized run against a transaction-level model.
module tb_maquina_de_cafe;

  localparam int TIMEOUT      = 16;
  localparam int SERVE_CYCLES = 4;

  localparam logic [7:0] HM = 8'h80;
  localparam logic [7:0] HA = 8'h40;
  localparam logic [7:0] BP = 8'h20;
  localparam logic [7:0] BC = 8'h10;
  localparam logic [7:0] BT = 8'h08;
  localparam logic [7:0] HC = 8'h04;
  localparam logic [7:0] MD = 8'h02;
  localparam logic [7:0] MC = 8'h01;

`ifdef TE_EN
  localparam bit TEA_BUILD = 1'b1;
`else
  localparam bit TEA_BUILD = 1'b0;
`endif

  // Model phases: where the customer is in the purchase, not a state encoding.
  localparam int P_IDLE = 0, P_WATER = 1, P_BUTTON = 2, P_COFFEE = 3, P_MONEY = 4, P_SERVE = 5, P_RETURN = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hm = 0, ha = 0, bp = 0, bc = 0, bt = 0, hc = 0, md = 0, mc = 0;
  logic [2:0] out;
  logic [3:0] state;

  int n_checks = 0;
  int n_pass   = 0;

  int m_phase = P_IDLE;
  int m_wait  = 0;
  int m_left  = 0;
  bit m_tea   = 1'b0;

  logic [6:0] exp_q[$];

  maquina_de_cafe #(.TIMEOUT(TIMEOUT), .SERVE_CYCLES(SERVE_CYCLES)) dut (
    .clk(clk), .rst(rst), .hm(hm), .ha(ha), .bp(bp), .bc(bc), .bt(bt),
    .hc(hc), .md(md), .mc(mc), .out(out), .state(state)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [7:0] v);
    {hm, ha, bp, bc, bt, hc, md, mc} = v;
  endtask

  task automatic model_reset();
    m_phase = P_IDLE;
    m_wait  = 0;
    m_left  = 0;
    m_tea   = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] v);
    int nxt;
    bit waiting;
    nxt = m_phase;
    case (m_phase)
      P_IDLE: begin
        m_tea = 1'b0;
        if (v[7]) nxt = P_WATER;
      end
      P_WATER:  if (v[6]) nxt = P_BUTTON;
      P_BUTTON: begin
        if (v[5] && v[4]) begin
          nxt = P_COFFEE; m_tea = 1'b0;
        end else if (TEA_BUILD && v[5] && v[3]) begin
          nxt = P_MONEY; m_tea = 1'b1;
        end
      end
      P_COFFEE: if (v[2]) nxt = P_MONEY;
      P_MONEY: begin
        if (v[0])      nxt = P_RETURN;
        else if (v[1]) nxt = P_SERVE;
      end
      P_SERVE: begin
        m_left = m_left - 1;
        if (m_left == 0) nxt = P_IDLE;
      end
      default: nxt = P_IDLE;
    endcase
    waiting = (m_phase >= P_WATER) && (m_phase <= P_MONEY);
    if (waiting && nxt == m_phase) begin
      m_wait = m_wait + 1;
      if (m_wait == TIMEOUT) nxt = P_RETURN;
    end
    if (nxt != m_phase) begin
      m_wait = 0;
      if (nxt == P_SERVE) m_left = SERVE_CYCLES;
    end
    m_phase = nxt;
  endtask

  function automatic logic [3:0] exp_state();
    case (m_phase)
      P_WATER:  return 4'b0001;
      P_BUTTON: return 4'b0011;
      P_COFFEE: return 4'b0100;
      P_MONEY:  return 4'b0101;
      P_SERVE:  return m_tea ? 4'b0111 : 4'b0110;
      P_RETURN: return 4'b0010;
      default:  return 4'b0000;
    endcase
  endfunction

  function automatic logic [2:0] exp_out();
    if (m_phase == P_SERVE)  return m_tea ? 3'b010 : 3'b001;
    if (m_phase == P_RETURN) return 3'b100;
    return 3'b000;
  endfunction

  task automatic step(input logic [7:0] v);
    drive(v);
    model_step(v);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      drive(8'($urandom));
      @(negedge clk);
      n_checks++;
      if ({state, out} !== 7'b0000_000)
        $display("FAIL reset_held cycle %0d: got state=%b out=%b, want state=0000 out=000", i, state, out);
      else n_pass++;
    end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step(8'($urandom) & ~HM);
      n_checks++;
      if ({state, out} !== 7'b0000_000)
        $display("FAIL reset_release cycle %0d: got state=%b out=%b, want state=0000 out=000", i, state, out);
      else n_pass++;
    end
  endtask

  task automatic test_coin_reject();
    logic [7:0] stim [6];
    logic [3:0] es [6];
    logic [2:0] eo [6];
    stim = '{HM, HA, BP | BC, HC, MC, 8'h00};
    es   = '{4'b0001, 4'b0011, 4'b0100, 4'b0101, 4'b0010, 4'b0000};
    eo   = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000};
    for (int i = 0; i < 6; i++) begin
      step(stim[i]);
      n_checks++;
      if ({state, out} !== {es[i], eo[i]})
        $display("FAIL coin_reject step %0d: got state=%b out=%b, want state=%b out=%b", i, state, out, es[i], eo[i]);
      else n_pass++;
    end
  endtask

  task automatic test_serve_coffee();
    logic [7:0] stim [9];
    logic [3:0] es [9];
    logic [2:0] eo [9];
    stim = '{HM, HA, BP | BC, HC, MD, 8'h00, 8'h00, 8'h00, 8'h00};
    es   = '{4'b0001, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0000};
    eo   = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000};
    for (int i = 0; i < 9; i++) begin
      step(stim[i]);
      n_checks++;
      if ({state, out} !== {es[i], eo[i]})
        $display("FAIL serve_coffee step %0d: got state=%b out=%b, want state=%b out=%b", i, state, out, es[i], eo[i]);
      else n_pass++;
    end
  endtask

  // bp alone waits, coffee wins over tea, and hm during serving is ignored.
  task automatic test_select_priority();
    logic [7:0] stim [10];
    logic [3:0] es [10];
    logic [2:0] eo [10];
    stim = '{HM, HA, BP, BP | BC | BT, HC, MD, HM, HM, HM, HM};
    es   = '{4'b0001, 4'b0011, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0000};
    eo   = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000};
    for (int i = 0; i < 10; i++) begin
      step(stim[i]);
      n_checks++;
      if ({state, out} !== {es[i], eo[i]})
        $display("FAIL select_priority step %0d: got state=%b out=%b, want state=%b out=%b", i, state, out, es[i], eo[i]);
      else n_pass++;
    end
  endtask

  task automatic test_tea();
`ifdef TE_EN
    logic [7:0] stim [8];
    logic [3:0] es [8];
    logic [2:0] eo [8];
    stim = '{HM, HA, BP | BT, MD, 8'h00, 8'h00, 8'h00, 8'h00};
    es   = '{4'b0001, 4'b0011, 4'b0101, 4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b0000};
    eo   = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b010, 3'b010, 3'b010, 3'b000};
    for (int i = 0; i < 8; i++) begin
      step(stim[i]);
      n_checks++;
      if ({state, out} !== {es[i], eo[i]})
        $display("FAIL tea step %0d: got state=%b out=%b, want state=%b out=%b", i, state, out, es[i], eo[i]);
      else n_pass++;
    end
`else
    logic [3:0] want_s;
    logic [2:0] want_o;
    step(HM);
    step(HA);
    for (int i = 1; i <= TIMEOUT; i++) begin
      step(i == 1 ? (BP | BT) : (i == 2 ? MD : 8'h00));
      want_s = (i == TIMEOUT) ? 4'b0010 : 4'b0011;
      want_o = (i == TIMEOUT) ? 3'b100 : 3'b000;
      n_checks++;
      if ({state, out} !== {want_s, want_o})
        $display("FAIL tea_disabled cycle %0d: got state=%b out=%b, want state=%b out=%b", i, state, out, want_s, want_o);
      else n_pass++;
    end
    step(8'h00);
    n_checks++;
    if ({state, out} !== 7'b0000_000)
      $display("FAIL tea_disabled_idle: got state=%b out=%b, want state=0000 out=000", state, out);
    else n_pass++;
`endif
  endtask

  task automatic test_timeout_water();
    logic [3:0] want_s;
    logic [2:0] want_o;
    step(HM);
    n_checks++;
    if ({state, out} !== 7'b0001_000)
      $display("FAIL timeout_entry: got state=%b out=%b, want state=0001 out=000", state, out);
    else n_pass++;
    for (int i = 1; i <= TIMEOUT; i++) begin
      step(8'($urandom) & ~HA);
      want_s = (i == TIMEOUT) ? 4'b0010 : 4'b0001;
      want_o = (i == TIMEOUT) ? 3'b100 : 3'b000;
      n_checks++;
      if ({state, out} !== {want_s, want_o})
        $display("FAIL timeout_water cycle %0d: got state=%b out=%b, want state=%b out=%b", i, state, out, want_s, want_o);
      else n_pass++;
    end
    step(8'h00);
    n_checks++;
    if ({state, out} !== 7'b0000_000)
      $display("FAIL timeout_idle: got state=%b out=%b, want state=0000 out=000", state, out);
    else n_pass++;
  endtask

  task automatic test_reset_mid_serve();
    step(HM); step(HA); step(BP | BC); step(HC); step(MD);
    n_checks++;
    if ({state, out} !== 7'b0110_001)
      $display("FAIL mid_serve_reach: got state=%b out=%b, want state=0110 out=001", state, out);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({state, out} !== 7'b0000_000)
      $display("FAIL async_reset: got state=%b out=%b, want state=0000 out=000", state, out);
    else n_pass++;
    model_reset();
    @(negedge clk);
    n_checks++;
    if ({state, out} !== 7'b0000_000)
      $display("FAIL reset_hold_serve: got state=%b out=%b, want state=0000 out=000", state, out);
    else n_pass++;
    rst = 1'b0;
    step(8'h00);
    n_checks++;
    if ({state, out} !== 7'b0000_000)
      $display("FAIL reset_after_release: got state=%b out=%b, want state=0000 out=000", state, out);
    else n_pass++;
  endtask

  function automatic logic [7:0] rand_inputs(input bit quiet);
    logic [7:0] v;
    if (quiet) return 8'h00;
    v[7] = ($urandom_range(99) < 30);
    v[6] = ($urandom_range(99) < 60);
    v[5] = ($urandom_range(99) < 50);
    v[4] = ($urandom_range(99) < 45);
    v[3] = ($urandom_range(99) < 50);
    v[2] = ($urandom_range(99) < 60);
    v[1] = ($urandom_range(99) < 50);
    v[0] = ($urandom_range(99) < 20);
    return v;
  endfunction

  task automatic test_random();
    logic [7:0] v;
    logic [6:0] e;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    exp_q.delete();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      // Periodic quiet windows force the wait-state timeouts to fire.
      v = rand_inputs((cyc % 150) >= 128);
      drive(v);
      model_step(v);
      exp_q.push_back({exp_state(), exp_out()});
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({state, out} !== e)
        $display("FAIL random cycle %0d in=%b: got state=%b out=%b, want state=%b out=%b", cyc, v, state, out, e[6:3], e[2:0]);
      else n_pass++;
    end
  endtask

  initial begin
    drive(8'h00);
    model_reset();
    test_reset();
    test_coin_reject();
    test_serve_coffee();
    test_select_priority();
    test_tea();
    test_timeout_water();
    test_reset_mid_serve();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
